fifo_stream_reader: RTL and testbench

- Read-side master for the team's 16-bit `fifo` block.
- Pops words from the FIFO's `rd`/`dout`/`valid`/`empty`/`under` interface and presents them on a downstream valid/ready stream.
- Absorbs the FIFO's one-cycle read latency with a small skid buffer, so no word is lost under backpressure.
- Sits between the FIFO and any consumer such as a serializer or DMA writer.

---
 rtl/fifo_stream_reader_pkg.sv | 5 +
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader_skid_buf.sv | 45 ++++
 rtl/fifo_stream_reader.sv | 72 +++++++
 tb/tb_fifo_stream_reader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_if_pkg: shared FIFO word width and the reader FSM state type
package fifo_if_pkg;
  localparam int FIFO_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port (rd/dout/valid/empty/under) plus downstream valid/ready stream; master = reader side
interface fifo_stream_reader_if
  import fifo_if_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);
  logic fifo_rd;
  logic [DATA_W-1:0] fifo_dout;
  logic fifo_valid;
  logic fifo_empty;
  logic fifo_under;
  logic [DATA_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport master (
    output fifo_rd, m_data, m_valid,
    input fifo_dout, fifo_valid, fifo_empty, fifo_under, m_ready
  );
  modport slave (
    input fifo_rd, m_data, m_valid,
    output fifo_dout, fifo_valid, fifo_empty, fifo_under, m_ready
  );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// skid_buf: DEPTH-entry circular buffer; push/push_data at tail, pop at head, occ count, head_data/head_valid (head_data is 0 when empty)
module skid_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OW-1:0]     occ,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic do_pop;
  assign occ = occ_q;
  assign head_valid = occ_q != '0;
  assign head_data = head_valid ? mem_q[rd_q] : '0;
  always_comb begin
    do_pop = pop && head_valid;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    occ_d = occ_q + OW'(push) - OW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops the fifo via bus.fifo_* into a skid buffer and streams it on bus.m_*; clk/rst, enable, word_count, sticky err_under, busy
module fifo_stream_reader
  import fifo_if_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W = 16,
  parameter int BACK_TO_BACK = 0,
  localparam int OW = $clog2(SKID_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     word_count,
  output logic                 err_under,
  output logic                 busy
);
  state_e state_q, state_d;
  logic [OW-1:0] occ, inflight_q, inflight_d;
  logic [OW:0] pending;
  logic rd_prev_q, capture, xfer;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic err_under_q, err_under_d;
  skid_buf #(.DATA_W(DATA_W), .DEPTH(SKID_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (capture),
    .push_data  (bus.fifo_dout),
    .pop        (bus.m_ready),
    .occ        (occ),
    .head_data  (bus.m_data),
    .head_valid (bus.m_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = enable ? RUN : (state_q == RUN || (state_q == DRAIN && busy)) ? DRAIN : IDLE;
  end
  // Reserving a slot per in-flight read guarantees every fifo_valid finds room.
  always_comb begin
    pending = {1'b0, occ} + {1'b0, inflight_q};
    busy = pending != '0;
    bus.fifo_rd = state_q == RUN && !bus.fifo_empty && pending < (OW + 1)'(SKID_DEPTH)
                  && (BACK_TO_BACK != 0 || !rd_prev_q);
  end
  // A fifo_valid with nothing in flight is a protocol error: flagged, never captured.
  always_comb begin
    capture = bus.fifo_valid && inflight_q != '0;
    xfer = bus.m_valid && bus.m_ready;
    inflight_d = inflight_q + OW'(bus.fifo_rd) - OW'(capture);
    word_count_d = word_count_q + CNT_W'(xfer);
    err_under_d = err_under_q || bus.fifo_under || (bus.fifo_valid && !capture);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      rd_prev_q <= 1'b0;
      word_count_q <= '0;
      err_under_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rd_prev_q <= bus.fifo_rd;
      word_count_q <= word_count_d;
      err_under_q <= err_under_d;
    end
  end
  assign word_count = word_count_q;
  assign err_under = err_under_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized scoreboard bench with a behavioural FIFO feeding the reader
module tb_fifo_stream_reader;
  import fifo_if_pkg::*;
  localparam int DW = FIFO_DATA_W;
  localparam int CW = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [CW-1:0] word_count;
  logic err_under, busy;
  fifo_stream_reader_if #(.DATA_W(DW)) bus ();
  fifo_stream_reader #(.DATA_W(DW), .SKID_DEPTH(DEPTH), .CNT_W(CW), .BACK_TO_BACK(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .word_count (word_count),
    .err_under  (err_under),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic inj_under = 1'b0;
  logic inj_valid = 1'b0;
  logic pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;
  int checks = 0;
  int errors = 0;
  int outst = 0;
  logic [CW-1:0] cnt_m = '0;
  logic err_m = 1'b0, en_prev = 1'b0, rd_prev = 1'b0, hold = 1'b0, lat1 = 1'b0, lat2 = 1'b0;
  logic [DW-1:0] held = '0;
  logic [DW-1:0] w;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  // Behavioural FIFO: one-cycle read latency, empty reflects the queue.
  initial begin
    bus.fifo_valid = 1'b0;
    bus.fifo_dout = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_under = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.fifo_valid = pend_v || inj_valid;
      bus.fifo_dout = pend_v ? pend_d : DW'($urandom);
      bus.fifo_under = inj_under;
      bus.fifo_empty = fq.size() == 0;
      pend_v = 1'b0;
      #1;
      if (bus.fifo_rd && !rst && fq.size() != 0) begin
        pend_d = fq.pop_front();
        pend_v = 1'b1;
      end
    end
  end
  // Monitor: checks the state produced by the last edge, then advances the model.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("busy", busy, outst != 0);
      chk("word_count", word_count, cnt_m);
      chk("err_under", err_under, err_m);
      if (outst == 0) chk("idle_m_valid", bus.m_valid, 0);
      if (hold) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, held);
      end
      if (lat2) chk("latency2_valid", bus.m_valid, 1);
      if (lat1) chk("latency1_early", bus.m_valid, 0);
      if (bus.fifo_rd) begin
        chk("rd_enabled", en_prev, 1);
        chk("rd_not_empty", bus.fifo_empty, 0);
        chk("rd_no_b2b", rd_prev, 0);
        chk("rd_bound", outst < DEPTH, 1);
      end
      if (rst) begin
        outst = 0;
        cnt_m = '0;
        err_m = 1'b0;
        en_prev = 1'b0;
        rd_prev = 1'b0;
        hold = 1'b0;
        lat1 = 1'b0;
        lat2 = 1'b0;
      end else begin
        lat2 = lat1;
        lat1 = bus.fifo_rd && outst == 0;
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word got %0h want none", bus.m_data);
          end else begin
            w = exp_q.pop_front();
            chk("m_data", bus.m_data, w);
          end
          cnt_m = cnt_m + 1'b1;
          outst--;
        end
        if (inj_under || inj_valid) err_m = 1'b1;
        hold = bus.m_valid && !bus.m_ready;
        held = bus.m_data;
        rd_prev = bus.fifo_rd;
        en_prev = enable;
        if (bus.fifo_rd) outst++;
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(input int n, input bit seq, input int base);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = seq ? DW'(base + i) : DW'($urandom);
      fq.push_back(v);
      exp_q.push_back(v);
    end
  endtask
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    enable = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d words left want 0", exp_q.size());
    end
    bus.m_ready = 1'b1;
    enable = 1'b0;
    cyc(4);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    fq.delete();
    exp_q.delete();
    cyc(1);
    rst = 1'b0;
  endtask
  initial begin
    int n;
    bus.m_ready = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    load(9, 1'b1, 1);
    drain(1'b0);
    chk("stream_count", word_count, 9);
    load(5, 1'b1, 1);
    bus.m_ready = 1'b0;
    enable = 1'b1;
    cyc(10);
    chk("bp_fifo_left", fq.size(), 3);
    chk("bp_head", bus.m_data, 1);
    drain(1'b0);
    chk("bp_count", word_count, 14);
    enable = 1'b1;
    cyc(10);
    chk("empty_no_valid", bus.m_valid, 0);
    enable = 1'b0;
    cyc(3);
    for (int p = 0; p < 6; p++) begin
      load($urandom_range(1, 12), 1'b0, 0);
      drain(1'b1);
    end
    inj_under = 1'b1;
    cyc(1);
    inj_under = 1'b0;
    cyc(5);
    chk("under_sticky", err_under, 1);
    do_reset();
    cyc(2);
    inj_valid = 1'b1;
    cyc(1);
    inj_valid = 1'b0;
    cyc(3);
    chk("spurious_err", err_under, 1);
    load(3, 1'b0, 0);
    drain(1'b1);
    load(4, 1'b0, 0);
    enable = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      #2;
      if (bus.fifo_rd) break;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL mid_rd_timeout got no fifo_rd want one");
    end
    enable = 1'b0;
    cyc(8);
    chk("disable_fifo_left", fq.size(), 3);
    chk("disable_delivered", exp_q.size(), 3);
    drain(1'b1);
    load(4, 1'b0, 0);
    bus.m_ready = 1'b0;
    enable = 1'b1;
    cyc(8);
    chk("pre_reset_busy", busy, 1);
    do_reset();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_count", word_count, 0);
    bus.m_ready = 1'b1;
    cyc(2);
    load(17, 1'b1, 1);
    drain(1'b1);
    chk("wrap_count", word_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
